alu_op_sequencer: RTL

- Initiator side of the ALU operand/operator interface: collects operand A, operand B and a 4-bit operator code from board switches, one per button press.
- Drives them onto the ALU inputs, waits a fixed settle time, then captures the ALU result and N/Z/C/V flags into holding registers for display.
- Sits between the board I/O (switches, push button) and the combinational ALU; the 7-segment decoder reads the captured registers.

---
 rtl/alu_op_sequencer_if.sv | 36 +++
 rtl/alu_op_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: operand/operator bus between the sequencer (initiator)
// and the combinational ALU.
//
// Signals:
//   alu_a, alu_b   N-bit operands driven by the sequencer.
//   alu_op         4-bit operator code driven by the sequencer.
//   alu_result     N-bit result returned by the ALU.
//   alu_flags      4-bit flags {N,Z,C,V} returned by the ALU.
//
// Handshake: there is no valid/ready pair on this bus. The ALU is purely
// combinational, so the initiator holds alu_a/alu_b/alu_op stable for a fixed
// number of settle cycles and samples alu_result/alu_flags at the end of that
// window.
//
// Modports:
//   master  sequencer side (drives operands/op, samples result/flags).
//   slave   ALU side (samples operands/op, drives result/flags).
interface alu_op_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;

    modport master (
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_flags
    );

    modport slave (
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_flags
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects operand A, operand B and an operator code from
// board switches (one per button press), presents them to a combinational
// ALU, waits SETTLE_CYCLES clocks and captures result and flags for display.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset.
//   sw_data      N-bit operand from switches (A or B depending on state).
//   sw_op        4-bit operator code from switches.
//   btn_next     raw asynchronous advance button (active high).
//   alu          master side of the ALU bus (alu_a/alu_b/alu_op out,
//                alu_result/alu_flags in).
//   result_q     captured result.
//   flags_q      captured flags {N,Z,C,V}.
//   err          last operation rejected (invalid op, or div/mod by zero).
//   valid        one-cycle pulse when result_q/flags_q/err update.
//   state_q      FSM state encoding for debug LEDs.
//
// Optional feature, macro ALU_SEQ_ACCUMULATE_EN: when defined, a press in
// SHOW loads alu_a from the captured result (0 if that result was rejected)
// and jumps straight to LOAD_B for chained calculations. When undefined, a
// press in SHOW returns to LOAD_A and alu_a is untouched until that load.
module alu_op_sequencer #(
    parameter int N             = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_data,
    input  logic [3:0]   sw_op,
    input  logic         btn_next,
    alu_op_sequencer_if.master alu,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic         err,
    output logic         valid,
    output logic [2:0]   state_q
);

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] FLAGS_REJECT = 4'b0100;  // Z only

    state_t       state, state_next;
    logic         sync1, sync2, sync2_d;
    logic         adv;
    logic [3:0]   cnt;
    logic [N-1:0] a_q, b_q;
    logic [3:0]   op_q;
    logic         load_a, load_b, load_op, cnt_clr, capture;
    logic         reject;
`ifdef ALU_SEQ_ACCUMULATE_EN
    logic         a_from_result;
`endif

    assign alu.alu_a  = a_q;
    assign alu.alu_b  = b_q;
    assign alu.alu_op = op_q;
    assign state_q    = state;

    // Rising edge of the synchronized button; exists for exactly one cycle.
    assign adv = sync2 & ~sync2_d;

    // Ops 3 and 4 are divide and modulo; codes above 9 are undefined.
    assign reject = (op_q > 4'b1001) ||
                    (((op_q == 4'b0011) || (op_q == 4'b0100)) && (b_q == '0));

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        cnt_clr    = 1'b0;
        capture    = 1'b0;
`ifdef ALU_SEQ_ACCUMULATE_EN
        a_from_result = 1'b0;
`endif
        case (state)
            S_LOAD_A: if (adv) begin
                load_a     = 1'b1;
                state_next = S_LOAD_B;
            end
            S_LOAD_B: if (adv) begin
                load_b     = 1'b1;
                state_next = S_LOAD_OP;
            end
            S_LOAD_OP: if (adv) begin
                load_op    = 1'b1;
                cnt_clr    = 1'b1;
                state_next = S_EXEC;
            end
            // adv is deliberately not looked at here, so a press landing in
            // the capture cycle is consumed by the edge detector and lost.
            S_EXEC: if (cnt == SETTLE_LAST) begin
                capture    = 1'b1;
                state_next = S_SHOW;
            end
            S_SHOW: if (adv) begin
`ifdef ALU_SEQ_ACCUMULATE_EN
                a_from_result = 1'b1;
                state_next    = S_LOAD_B;
`else
                state_next    = S_LOAD_A;
`endif
            end
            default: state_next = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync2_d  <= 1'b0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            sync1   <= btn_next;
            sync2   <= sync1;
            sync2_d <= sync2;
            valid   <= capture;

            if (load_a) begin
                a_q <= sw_data;
            end
`ifdef ALU_SEQ_ACCUMULATE_EN
            else if (a_from_result) begin
                a_q <= err ? '0 : result_q;
            end
`endif
            if (load_b) begin
                b_q <= sw_data;
            end
            if (load_op) begin
                op_q <= sw_op;
            end

            // Counter runs only while in EXEC and freezes on the exit cycle.
            if (cnt_clr) begin
                cnt <= '0;
            end else if ((state == S_EXEC) && !capture) begin
                cnt <= cnt + 4'd1;
            end

            if (capture) begin
                err      <= reject;
                result_q <= reject ? '0 : alu.alu_result;
                flags_q  <= reject ? FLAGS_REJECT : alu.alu_flags;
            end
        end
    end

endmodule
